uart_rx: RTL and testbench

//  Serial UART receiver feeding the 8-bit RX FIFO of the UART peripheral.

---
 rtl/uart_rx_pkg.sv | 17 +
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// No logic; pure declarations.
// Optional parity build selected with UART_RX_PARITY_EN.
package uart_rx_pkg;

  localparam int UART_DATA_W    = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Bundle of the receiver's tick/pad/FIFO-side signals.
// master = receiver (drives byte and status), slave = surrounding peripheral.
// No flow control: fifo_full is a status input only.
interface uart_rx_if import uart_rx_pkg::*; ();

  logic                   b_tick;
  logic                   rxd;
  logic                   fifo_full;
  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_done;
  logic                   rx_busy;
  logic                   frame_err;
  logic                   overrun;
  logic                   parity_err;

  modport master (
    input  b_tick, rxd, fifo_full,
    output rx_data, rx_done, rx_busy, frame_err, overrun, parity_err
  );

  modport slave (
    output b_tick, rxd, fifo_full,
    input  rx_data, rx_done, rx_busy, frame_err, overrun, parity_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rxd pad, resets to idle-high.
// Latency: 2 clk.
// No backpressure.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // shift the pad value through two flops; reset to 1 so no false start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled 8N1 UART receiver (8E1/8O1 when UART_RX_PARITY_EN is defined).
// Latency: rx_done one clk after the stop-bit centre tick (+2 clk pad sync).
// No backpressure: a byte completed while fifo_full=1 is still strobed and flagged as overrun.
module uart_rx import uart_rx_pkg::*; #(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  // tick_cnt is a fixed 4-bit counter; centre and end-of-bit match points
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(UART_DATA_W - 1);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_STOP   = STOP;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = PARITY;
`endif

  logic rx_s;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rxd),
    .q_o (rx_s)
  );

  logic [2:0]             state_q, state_d;
  logic [3:0]             tick_q,  tick_d;
  logic [2:0]             bit_q,   bit_d;
  logic [UART_DATA_W-1:0] sr_q,    sr_d;
  logic [UART_DATA_W-1:0] data_q,  data_d;
  logic                   done_q,  done_d;
  logic                   ferr_q,  ferr_d;
  logic                   ovr_q,   ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                   pflag_q, pflag_d;
  logic                   perr_q,  perr_d;
`endif

  // next-state logic: everything holds except on b_tick; pulses default low
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    pflag_d = pflag_q;
    perr_d  = 1'b0;
`endif
    if (bus.b_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            tick_d  = 4'd0;
          end
        end
        S_START: begin
          if (tick_q == TICK_MID) begin
            // low at mid start bit confirms a real frame; high was a glitch
            if (!rx_s) begin
              state_d = S_DATA;
              tick_d  = 4'd0;
              bit_d   = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        S_DATA: begin
          if (tick_q == TICK_LAST) begin
            sr_d   = {rx_s, sr_q[UART_DATA_W-1:1]};
            tick_d = 4'd0;
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_q == TICK_LAST) begin
            pflag_d = ((^sr_q) ^ rx_s) != PARITY_ODD;
            tick_d  = 4'd0;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
`endif
        S_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = 4'd0;
            state_d = S_IDLE;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (pflag_q) begin
                perr_d = 1'b1;
              end else begin
                data_d = sr_q;
                done_d = 1'b1;
                ovr_d  = bus.fifo_full;
              end
`else
              data_d = sr_q;
              done_d = 1'b1;
              ovr_d  = bus.fifo_full;
`endif
            end else begin
              // bad stop bit wins over any parity result
              ferr_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tick_d  = 4'd0;
        end
      endcase
    end
  end

  // state and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= 4'd0;
      bit_q   <= 3'd0;
      sr_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pflag_q <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      pflag_q <= pflag_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_done   = done_q;
  assign bus.rx_busy   = (state_q != S_IDLE);
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 100 MHz clk, b_tick every 54 clk.
// Frames are driven bit-aligned to b_tick; outputs sampled on the falling edge.
// Parity case is compiled in only with UART_RX_PARITY_EN.
module tb_uart_rx;
  import uart_rx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_tick = 1'b0;
  logic rxd = 1'b1;
  logic fifo_full = 1'b0;
  int   tdiv = 0;

  uart_rx_if bus ();

  assign bus.b_tick    = b_tick;
  assign bus.rxd       = rxd;
  assign bus.fifo_full = fifo_full;

  uart_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // 16x baud enable: one clk high every 54 clk
  always @(posedge clk) begin
    if (tdiv == 53) begin
      tdiv   <= 0;
      b_tick <= 1'b1;
    end else begin
      tdiv   <= tdiv + 1;
      b_tick <= 1'b0;
    end
  end

  // event monitor: counts every clk each pulse is high, captures strobed bytes
  int n_done = 0, n_ferr = 0, n_ovr = 0, n_ovr_co = 0, n_perr = 0;
  logic [7:0] cap0 = 8'h00, cap1 = 8'h00;
  always @(negedge clk) begin
    if (bus.rx_done) begin
      n_done++;
      cap0 = cap1;
      cap1 = bus.rx_data;
      if (bus.overrun) n_ovr_co++;
    end
    if (bus.frame_err)  n_ferr++;
    if (bus.overrun)    n_ovr++;
    if (bus.parity_err) n_perr++;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // return 1 time unit after the n-th clk edge on which b_tick is seen high
  task automatic wait_tick(input int n);
    repeat (n) begin
      do @(posedge clk); while (b_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic bit_out(input logic v);
    rxd = v;
    wait_tick(16);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    wait_tick(n);
  endtask

  // start, 8 data LSB first, [even parity], stop
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(^d);
`endif
    bit_out(stop_b);
    rxd = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_b);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(par_b);
    bit_out(1'b1);
  endtask
`endif

  int d0, f0, o0, c0, p0;

  task automatic snap();
    d0 = n_done; f0 = n_ferr; o0 = n_ovr; c0 = n_ovr_co; p0 = n_perr;
  endtask

  initial begin
    // reset values
    repeat (5) @(posedge clk);
    #1;
    chk("rst_done",  32'(bus.rx_done),    32'd0);
    chk("rst_busy",  32'(bus.rx_busy),    32'd0);
    chk("rst_data",  32'(bus.rx_data),    32'h00);
    chk("rst_ferr",  32'(bus.frame_err),  32'd0);
    chk("rst_ovr",   32'(bus.overrun),    32'd0);
    chk("rst_perr",  32'(bus.parity_err), 32'd0);
    rst = 1'b0;
    idle(3);

    // 1: single 0x55 frame
    snap();
    send_frame(8'h55, 1'b1);
    chk("t1_ndone", 32'(n_done - d0), 32'd1);
    chk("t1_data",  32'(cap1),        32'h55);
    chk("t1_ferr",  32'(n_ferr - f0), 32'd0);
    chk("t1_ovr",   32'(n_ovr - o0),  32'd0);
    chk("t1_busy",  32'(bus.rx_busy), 32'd0);
    idle(3);
    chk("t1_hold",  32'(bus.rx_data), 32'h55);

    // 2: back-to-back 0xA3, 0x0F with no idle bit between
    snap();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    chk("t2_ndone", 32'(n_done - d0), 32'd2);
    chk("t2_first", 32'(cap0),        32'hA3);
    chk("t2_second",32'(cap1),        32'h0F);
    idle(3);

    // 3: start-bit glitch of 4 ticks
    snap();
    rxd = 1'b0;
    wait_tick(2);
    chk("t3_busy_hi", 32'(bus.rx_busy), 32'd1);
    wait_tick(2);
    rxd = 1'b1;
    wait_tick(8);
    chk("t3_busy_lo", 32'(bus.rx_busy), 32'd0);
    chk("t3_ndone",   32'(n_done - d0), 32'd0);
    chk("t3_ferr",    32'(n_ferr - f0), 32'd0);
    idle(3);

    // 4: 0x3C with stop bit low
    snap();
    send_frame(8'h3C, 1'b0);
    idle(12);
    chk("t4_ferr",  32'(n_ferr - f0), 32'd1);
    chk("t4_ndone", 32'(n_done - d0), 32'd0);
    chk("t4_data",  32'(bus.rx_data), 32'h0F);
    chk("t4_busy",  32'(bus.rx_busy), 32'd0);

    // 5: 0x81 while FIFO full
    snap();
    fifo_full = 1'b1;
    send_frame(8'h81, 1'b1);
    fifo_full = 1'b0;
    chk("t5_ndone", 32'(n_done - d0),   32'd1);
    chk("t5_ovr_co",32'(n_ovr_co - c0), 32'd1);
    chk("t5_novr",  32'(n_ovr - o0),    32'd1);
    chk("t5_data",  32'(cap1),          32'h81);
    idle(3);

    // 6: reset in the middle of 0xFF's data bits
    snap();
    bit_out(1'b0);
    for (int i = 0; i < 3; i++) bit_out(1'b1);
    wait_tick(5);
    chk("t6_busy_pre", 32'(bus.rx_busy), 32'd1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_rst_data", 32'(bus.rx_data), 32'h00);
    chk("t6_rst_busy", 32'(bus.rx_busy), 32'd0);
    rst = 1'b0;
    idle(100);
    chk("t6_nostrobe", 32'(n_done - d0), 32'd0);
    chk("t6_noferr",   32'(n_ferr - f0), 32'd0);
    send_frame(8'h12, 1'b1);
    chk("t6_ndone", 32'(n_done - d0), 32'd1);
    chk("t6_data",  32'(cap1),        32'h12);
    idle(3);

`ifdef UART_RX_PARITY_EN
    // 7: even parity, 0x07 has three ones
    snap();
    send_frame_par(8'h07, 1'b1);
    chk("t7_good_done", 32'(n_done - d0), 32'd1);
    chk("t7_good_data", 32'(cap1),        32'h07);
    chk("t7_good_perr", 32'(n_perr - p0), 32'd0);
    idle(3);
    snap();
    send_frame_par(8'h07, 1'b0);
    chk("t7_bad_perr", 32'(n_perr - p0), 32'd1);
    chk("t7_bad_done", 32'(n_done - d0), 32'd0);
    chk("t7_bad_ferr", 32'(n_ferr - f0), 32'd0);
    idle(3);
`else
    chk("perr_never", 32'(n_perr), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
